clk_pulse_gen: RTL and testbench

Multi-channel, run-time programmable clock/pulse generator: the synthesizable successor to the parameter-only behavioural clock_gen. Each channel divides the system clock by a programmable period with a programmable high time (duty) and has its own enable. Stops are glitch-free. Period and duty can be reconfigured through a valid/ready write port, and a change takes effect only on a period boundary. It sits beside the clock/timing logic and drives strobes, test clocks and PWM-style enables.

---
 rtl/clk_pulse_gen.sv | 141 ++++++++++++++
 tb/tb_clk_pulse_gen.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_pulse_gen.sv
// clk_pulse_gen
//   Multi-channel programmable clock/pulse generator. Each channel divides clk
//   by a run-time period P and holds the output high for H cycles per period.
//   Period/high-time updates arrive through a valid/ready write port and are
//   staged in shadow registers. They take effect only on a period boundary, or
//   right away while the channel is idle. Stopping always finishes the current
//   period, so no runt pulses are produced.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous reset, active high
//   enable      per-channel run request (level)
//   cfg_valid   config write request
//   cfg_ready   write can be accepted for the channel on cfg_ch
//   cfg_ch      target channel of the write
//   cfg_period  period P in clk cycles
//   cfg_high    high time H in clk cycles
//   clk_out     generated outputs (straight from flops)
//   active      channel is running
//
// Per-channel FSM
//   state  | meaning
//   IDLE   | output low; pending config copied in; waits for enable with P >= 2
//   RUN    | counting 0..P-1; output high while cnt < H; exits only at a wrap
module clk_pulse_gen #(
  parameter int CHANNELS   = 4,
  parameter int CNT_W      = 16,
  parameter int DEF_PERIOD = 2,
  parameter int DEF_HIGH   = 1,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] enable,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic [CNT_W-1:0]    cfg_high,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] active
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam int NSLOT = 1 << CH_W;

  logic [CHANNELS-1:0] pending;
  logic [NSLOT-1:0]    pend_ext;

  // Channel numbers beyond CHANNELS read as "not pending", so the port is
  // always ready for them and the write simply matches no channel.
  always_comb begin
    pend_ext                 = '0;
    pend_ext[CHANNELS-1:0]   = pending;
  end

  assign cfg_ready = ~pend_ext[cfg_ch];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0] per_q, high_q, per_sh_q, high_sh_q;
    logic [CNT_W-1:0] per_nx, high_nx;
    logic             pend_q, clk_q, clk_d;
    logic             wr, xfer, wrap, run;

    // pending and a new write never coexist: a write needs pend_q == 0,
    // a transfer needs pend_q == 1.
    assign wr = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q   <= S_IDLE;
        cnt_q     <= '0;
        clk_q     <= 1'b0;
        pend_q    <= 1'b0;
        per_q     <= CNT_W'(DEF_PERIOD);
        high_q    <= CNT_W'(DEF_HIGH);
        per_sh_q  <= CNT_W'(DEF_PERIOD);
        high_sh_q <= CNT_W'(DEF_HIGH);
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        clk_q   <= clk_d;
        pend_q  <= wr | (pend_q & ~xfer);
        if (xfer) begin
          per_q  <= per_sh_q;
          high_q <= high_sh_q;
        end
        if (wr) begin
          per_sh_q  <= cfg_period;
          high_sh_q <= cfg_high;
        end
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      clk_d   = 1'b0;
      xfer    = 1'b0;
      wrap    = 1'b0;
      cnt_inc = cnt_q + CNT_W'(1);
      // Configuration in force for the next period if a transfer happens now.
      per_nx  = pend_q ? per_sh_q : per_q;
      high_nx = pend_q ? high_sh_q : high_q;
      if (state_q == S_IDLE) begin
        if (pend_q) begin
          // Transfer edge only; a start waits for the next edge.
          xfer = 1'b1;
        end else if (enable[i] && (per_q >= CNT_W'(2))) begin
          state_d = S_RUN;
          clk_d   = (high_q != '0);
        end
      end else begin
        wrap = (cnt_q == per_q - CNT_W'(1));
        if (wrap) begin
          xfer = pend_q;
          if (!enable[i] || (per_nx < CNT_W'(2))) begin
            state_d = S_IDLE;
          end else begin
            clk_d = (high_nx != '0);
          end
        end else begin
          cnt_d = cnt_inc;
          clk_d = (cnt_inc < high_q);
        end
      end
    end

    always_comb begin
      run = (state_q == S_RUN);
    end

    assign active[i]  = run;
    assign clk_out[i] = clk_q;
    assign pending[i] = pend_q;
  end

endmodule

// File: tb/tb_clk_pulse_gen.sv
module tb_clk_pulse_gen;
  localparam int CH = 4;
  localparam int W  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] enable = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [1:0]    cfg_ch = '0;
  logic [W-1:0]  cfg_period = '0;
  logic [W-1:0]  cfg_high = '0;
  logic [CH-1:0] clk_out, active;

  // second instance with a non-power-of-two channel count
  logic [2:0]    enable_b = '0;
  logic          cfg_valid_b = 1'b0;
  logic          cfg_ready_b;
  logic [1:0]    cfg_ch_b = '0;
  logic [W-1:0]  cfg_period_b = '0;
  logic [W-1:0]  cfg_high_b = '0;
  logic [2:0]    clk_out_b, active_b;

  int n_tests = 0;
  int n_fail  = 0;

  clk_pulse_gen #(.CHANNELS(CH), .CNT_W(W), .DEF_PERIOD(2), .DEF_HIGH(1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
    .cfg_high(cfg_high), .clk_out(clk_out), .active(active)
  );

  clk_pulse_gen #(.CHANNELS(3), .CNT_W(W), .DEF_PERIOD(2), .DEF_HIGH(1)) dut_b (
    .clk(clk), .rst(rst), .enable(enable_b), .cfg_valid(cfg_valid_b),
    .cfg_ready(cfg_ready_b), .cfg_ch(cfg_ch_b), .cfg_period(cfg_period_b),
    .cfg_high(cfg_high_b), .clk_out(clk_out_b), .active(active_b)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  // Reference model: per channel, current config, staged config, running flag
  // and position within the period. Output is "running and position < H".
  int mp[CH], mh[CH], sp[CH], sh[CH], mpos[CH];
  bit mpend[CH], mrun[CH];
  bit last_acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      mp[c] = 2; mh[c] = 1; sp[c] = 2; sh[c] = 1;
      mpend[c] = 0; mrun[c] = 0; mpos[c] = 0;
    end
  endfunction

  function automatic logic [CH-1:0] exp_clk();
    logic [CH-1:0] e;
    for (int c = 0; c < CH; c++) e[c] = mrun[c] && (mpos[c] < mh[c]);
    return e;
  endfunction

  function automatic logic [CH-1:0] exp_act();
    logic [CH-1:0] e;
    for (int c = 0; c < CH; c++) e[c] = mrun[c];
    return e;
  endfunction

  function automatic void model_edge(input logic [CH-1:0] en, input bit acc,
                                     input int ach, input int ap, input int ah);
    for (int c = 0; c < CH; c++) begin
      if (!mrun[c]) begin
        if (mpend[c]) begin
          mp[c] = sp[c]; mh[c] = sh[c]; mpend[c] = 0;
        end else if (en[c] && mp[c] >= 2) begin
          mrun[c] = 1; mpos[c] = 0;
        end
      end else if (mpos[c] == mp[c] - 1) begin
        if (mpend[c]) begin
          mp[c] = sp[c]; mh[c] = sh[c]; mpend[c] = 0;
        end
        mpos[c] = 0;
        if (!en[c] || mp[c] < 2) mrun[c] = 0;
      end else begin
        mpos[c]++;
      end
    end
    if (acc) begin
      sp[ach] = ap; sh[ach] = ah; mpend[ach] = 1;
    end
  endfunction

  task automatic tick();
    logic [CH-1:0] en_s;
    bit acc, rdy;
    int ach, ap, ah;
    #1;
    rdy = !mpend[cfg_ch];
    chk("cfg_ready", cfg_ready, rdy);
    acc  = cfg_valid && rdy;
    en_s = enable; ach = cfg_ch; ap = cfg_period; ah = cfg_high;
    @(posedge clk);
    model_edge(en_s, acc, ach, ap, ah);
    #1;
    chk("clk_out", clk_out, exp_clk());
    chk("active", active, exp_act());
    last_acc = acc;
  endtask

  task automatic wait_pos(input int c, input int target, input int budget);
    int n = 0;
    while (!(mrun[c] && mpos[c] == target) && n < budget) begin
      tick(); n++;
    end
    chk("wait_pos_bound", (mrun[c] && mpos[c] == target), 1);
  endtask

  task automatic idle_write(input int c, input int p, input int h);
    cfg_valid = 1; cfg_ch = 2'(c); cfg_period = W'(p); cfg_high = W'(h);
    tick();
    cfg_valid = 0;
    #1 chk("idle_pend", cfg_ready, 0);
    tick();
    #1 chk("idle_xfer", cfg_ready, 1);
  endtask

  task automatic live_write(input int c, input int p, input int h);
    int n = 0;
    cfg_valid = 1; cfg_ch = 2'(c); cfg_period = W'(p); cfg_high = W'(h);
    last_acc = 0;
    while (!last_acc && n < 20) begin
      tick(); n++;
    end
    chk("live_write_bound", last_acc, 1);
    cfg_valid = 0;
  endtask

  initial begin
    int k;
    logic [3:0] ec;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_clk", clk_out, 0);
    chk("rst_act", active, 0);
    chk("rst_rdy", cfg_ready, 1);
    rst = 0;

    // defaults: ch0 at 2/1
    enable = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("def_pat", clk_out[0], (i % 2 == 0) ? 1 : 0);
      chk("def_oth", {clk_out[3:1], active[3:1]}, 0);
      chk("def_act", active[0], 1);
    end
    enable = 4'b0000;
    tick();
    chk("def_stop", active[0], 0);

    // duty variety
    idle_write(1, 4, 1);
    idle_write(2, 4, 3);
    idle_write(3, 5, 3);
    enable = 4'b1111;
    for (int j = 0; j < 20; j++) begin
      tick();
      ec[0] = (j % 2) < 1;
      ec[1] = (j % 4) < 1;
      ec[2] = (j % 4) < 3;
      ec[3] = (j % 5) < 3;
      chk("duty_pat", clk_out, ec);
    end

    // live reconfigure ch0 to 10/5, then a stalled second write of 6/2
    cfg_valid = 1; cfg_ch = 0; cfg_period = 10; cfg_high = 5;
    tick();
    chk("live_acc", last_acc, 1);
    cfg_period = 6; cfg_high = 2;
    #1 chk("live_busy", cfg_ready, 0);
    k = 0;
    while (cfg_ready == 0 && k < 4) begin
      tick();
      chk("live_stall", last_acc, 0);
      #1;
      k++;
    end
    chk("live_rdy_back", cfg_ready, 1);
    chk("live_p0", clk_out[0], 1);
    for (int i = 1; i < 16; i++) begin
      tick();
      if (i == 1) begin
        chk("live_second_acc", last_acc, 1);
        cfg_valid = 0;
      end
      chk("live_pat", clk_out[0], (i < 10) ? (i < 5) : ((i - 10) < 2));
    end

    // graceful stop on ch3 (5/3)
    wait_pos(3, 1, 10);
    enable[3] = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stop_clk", clk_out[3], (i == 0) ? 1 : 0);
      chk("stop_act", active[3], (i < 3) ? 1 : 0);
    end
    enable[3] = 1;
    tick();
    chk("restart", {active[3], clk_out[3]}, 2'b11);
    wait_pos(3, 1, 10);
    enable[3] = 0;
    tick(); tick();
    chk("reen_pos3", clk_out[3], 0);
    enable[3] = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reen_act", active[3], 1);
      chk("reen_clk", clk_out[3], (i == 0) ? 0 : 1);
    end

    // corner configs
    live_write(1, 4, 0);
    live_write(2, 4, 7);
    live_write(0, 1, 1);
    repeat (12) tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("h0_low", {active[1], clk_out[1]}, 2'b10);
      chk("hbig_high", {active[2], clk_out[2]}, 2'b11);
      chk("p1_idle", {active[0], clk_out[0]}, 2'b00);
    end

    // out-of-range channel on a 3-channel instance
    cfg_ch_b = 2'd3; cfg_valid_b = 1; cfg_period_b = 5; cfg_high_b = 2;
    #1 chk("oor_rdy", cfg_ready_b, 1);
    tick();
    cfg_valid_b = 0;
    for (int c = 0; c < 3; c++) begin
      cfg_ch_b = 2'(c);
      #1 chk("oor_drop", cfg_ready_b, 1);
    end
    cfg_ch_b = 2'd1; cfg_valid_b = 1;
    tick();
    cfg_valid_b = 0;
    #1 chk("b_pend", cfg_ready_b, 0);
    tick();
    #1 chk("b_xfer", cfg_ready_b, 1);
    chk("b_idle", {clk_out_b, active_b}, 0);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 5) == 0) enable[$urandom_range(0, CH-1)] = ($urandom_range(0, 3) != 0);
      cfg_valid  = ($urandom_range(0, 3) == 0);
      cfg_ch     = 2'($urandom_range(0, CH-1));
      cfg_period = W'($urandom_range(0, 9));
      cfg_high   = W'($urandom_range(0, 10));
      tick();
    end

    // async reset during a high phase
    cfg_valid = 0;
    enable = 4'b1111;
    k = 0;
    while (exp_clk() == 0 && k < 50) begin
      tick(); k++;
    end
    chk("high_seen", (exp_clk() != 0), 1);
    #2 rst = 1;
    #1;
    chk("arst_clk", clk_out, 0);
    chk("arst_act", active, 0);
    chk("arst_rdy", cfg_ready, 1);
    model_reset();
    #1 rst = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_pat", clk_out, (i % 2 == 0) ? 4'hF : 4'h0);
      chk("post_rst_act", active, 4'hF);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
